// File: rtl/mitch_pkg.sv
// Shared widths, constants and stage payloads for the Mitchell divider.
package mitch_pkg;

  localparam int W_IN   = 16;
  localparam int W_FRAC = 7;
  localparam int W_L    = 12;
  localparam int W_Q    = 32;
  localparam int W_K    = 4;

  localparam logic [W_L-1:0] BIAS_DIV = 12'd3;

  typedef struct packed {
    logic              sign;
    logic              xneg;
    logic              xz;
    logic              yz;
    logic [W_K-1:0]    kx;
    logic [W_FRAC-1:0] fx;
    logic [W_K-1:0]    ky;
    logic [W_FRAC-1:0] fy;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic                  xneg;
    logic                  xz;
    logic                  yz;
    logic signed [W_L-1:0] l;
  } s2_t;

endpackage

// File: rtl/mitch_log_enc.sv
// Log encoder: magnitude -> zero flag, leading-one index, 7-bit truncated fraction.
module mitch_log_enc
  import mitch_pkg::*;
(
  input  logic [W_IN-1:0]   a,
  output logic              zero,
  output logic [W_K-1:0]    k,
  output logic [W_FRAC-1:0] f
);

  logic [W_IN-1:0] norm;

  always_comb begin
    k = '0;
    for (int i = 0; i < W_IN; i++) begin
      if (a[i]) k = W_K'(i);
    end
  end

  // leading one moves to bit 15; the next 7 bits are the fraction
  assign norm = a << (4'd15 - k);
  assign f    = W_FRAC'(norm >> 8);
  assign zero = (a == '0);

endmodule

// File: rtl/mitch_trunc_div_w8.sv
// Three-stage Mitchell log-domain divider, Q16.16 out, valid/ready on both sides.
// Optional MITCH_DIV_BIAS_EN subtracts a small error-compensation bias from L.
module mitch_trunc_div_w8
  import mitch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [W_IN-1:0] x_i,
  input  logic [W_IN-1:0] y_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [W_Q-1:0]  q_o,
  output logic            dz_o,
  output logic            valid_o,
  input  logic            ready_i
);

  logic adv;
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  logic [W_IN-1:0]   ax, ay;
  logic              xz, yz;
  logic [W_K-1:0]    kx, ky;
  logic [W_FRAC-1:0] fx, fy;

  assign ax = x_i[W_IN-1] ? W_IN'(-x_i) : x_i;
  assign ay = y_i[W_IN-1] ? W_IN'(-y_i) : y_i;

  mitch_log_enc u_enc_x (
    .a    (ax),
    .zero (xz),
    .k    (kx),
    .f    (fx)
  );

  mitch_log_enc u_enc_y (
    .a    (ay),
    .zero (yz),
    .k    (ky),
    .f    (fy)
  );

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1, v2;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = x_i[W_IN-1] ^ y_i[W_IN-1];
    s1_d.xneg = x_i[W_IN-1];
    s1_d.xz   = xz;
    s1_d.yz   = yz;
    s1_d.kx   = kx;
    s1_d.fx   = fx;
    s1_d.ky   = ky;
    s1_d.fy   = fy;
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.xneg = s1_q.xneg;
    s2_d.xz   = s1_q.xz;
    s2_d.yz   = s1_q.yz;
`ifdef MITCH_DIV_BIAS_EN
    s2_d.l    = $signed({1'b0, s1_q.kx, s1_q.fx})
              - $signed({1'b0, s1_q.ky, s1_q.fy})
              - $signed(BIAS_DIV);
`else
    s2_d.l    = $signed({1'b0, s1_q.kx, s1_q.fx})
              - $signed({1'b0, s1_q.ky, s1_q.fy});
`endif
  end

  logic signed [5:0] sh;
  logic [7:0]        mant;
  logic [W_Q-1:0]    mag;
  logic [W_Q-1:0]    q_d;
  logic              dz_d;

  // ke = L>>>7 is the top 5 bits; Q16.16 scaling adds 9 to the shift
  always_comb begin
    mant = {1'b1, s2_q.l[6:0]};
    sh   = 6'($signed(s2_q.l[W_L-1:7])) + 6'sd9;
    mag  = '0;
    q_d  = '0;
    dz_d = 1'b0;
    if (!sh[5]) mag = W_Q'(mant) << sh[4:0];
    else        mag = W_Q'(mant) >> (~sh[2:0] + 3'd1);
    if (mag[W_Q-1]) mag = 32'h7FFF_FFFF;
    if (s2_q.yz) begin
      dz_d = 1'b1;
      q_d  = s2_q.xneg ? 32'h8000_0001 : 32'h7FFF_FFFF;
    end else if (s2_q.xz) begin
      q_d  = '0;
    end else begin
      q_d  = s2_q.sign ? W_Q'(-mag) : mag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      valid_o <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      q_o     <= '0;
      dz_o    <= 1'b0;
    end else if (adv) begin
      v1      <= valid_i;
      v2      <= v1;
      valid_o <= v2;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      q_o     <= q_d;
      dz_o    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mitch_trunc_div_w8.sv
// Directed bench for mitch_trunc_div_w8; expected values hand-derived.
module tb_mitch_trunc_div_w8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [15:0] x_i, y_i;
  logic        valid_i, ready_o;
  logic [31:0] q_o;
  logic        dz_o, valid_o, ready_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mitch_trunc_div_w8 dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .x_i     (x_i),
    .y_i     (y_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .q_o     (q_o),
    .dz_o    (dz_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

`ifdef MITCH_DIV_BIAS_EN
  localparam logic [31:0] E_100_10 = 32'h000A_5000;
  localparam logic [31:0] E_M64_8  = 32'hFFF8_1800;
  localparam logic [31:0] E_7_M7   = 32'hFFFF_0300;
  localparam logic [31:0] E_1_MAX  = 32'h0000_0001;
  localparam logic [31:0] E_MIN_1  = 32'h8180_0000;
`else
  localparam logic [31:0] E_100_10 = 32'h000A_8000;
  localparam logic [31:0] E_M64_8  = 32'hFFF8_0000;
  localparam logic [31:0] E_7_M7   = 32'hFFFF_0000;
  localparam logic [31:0] E_1_MAX  = 32'h0000_0002;
  localparam logic [31:0] E_MIN_1  = 32'h8000_0001;
`endif

  // drive one beat at a negedge; sample 2 and 3 edges after capture
  task automatic run_one(input logic [15:0] xv, input logic [15:0] yv,
                         output logic [31:0] qv, output logic dzv,
                         output logic early, output logic late);
    x_i = xv; y_i = yv; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    early = valid_o;
    @(negedge clk);
    late = valid_o; qv = q_o; dzv = dz_o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; x_i = '0; y_i = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
    n_vec++; if (q_o !== 32'h0) begin n_err++; $display("FAIL rst_q got=%h exp=00000000", q_o); end
    n_vec++; if (dz_o !== 1'b0) begin n_err++; $display("FAIL rst_dz got=%b exp=0", dz_o); end
    rst_ni = 1'b1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] q; logic dz, e, l;
    run_one(16'd100, 16'd10, q, dz, e, l);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL lat_early got=%b exp=0", e); end
    n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL lat_exact got=%b exp=1", l); end
    n_vec++; if (q !== E_100_10) begin n_err++; $display("FAIL div_100_10 got=%h exp=%h", q, E_100_10); end
    n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL dz_100_10 got=%b exp=0", dz); end
    run_one(-16'sd64, 16'd8, q, dz, e, l);
    n_vec++; if (q !== E_M64_8) begin n_err++; $display("FAIL div_m64_8 got=%h exp=%h", q, E_M64_8); end
    n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL dz_m64_8 got=%b exp=0", dz); end
    run_one(16'd7, -16'sd7, q, dz, e, l);
    n_vec++; if (q !== E_7_M7) begin n_err++; $display("FAIL div_7_m7 got=%h exp=%h", q, E_7_M7); end
  endtask

  task automatic test_trunc();
    logic [31:0] q; logic dz, e, l;
    run_one(16'd1, 16'd32767, q, dz, e, l);
    n_vec++; if (q !== E_1_MAX) begin n_err++; $display("FAIL div_1_max got=%h exp=%h", q, E_1_MAX); end
  endtask

  task automatic test_sat_dz();
    logic [31:0] q; logic dz, e, l;
    run_one(16'h8000, 16'd1, q, dz, e, l);
    n_vec++; if (q !== E_MIN_1) begin n_err++; $display("FAIL div_min_1 got=%h exp=%h", q, E_MIN_1); end
    run_one(16'd5, 16'd0, q, dz, e, l);
    n_vec++; if (q !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL dz_pos_q got=%h exp=7fffffff", q); end
    n_vec++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_pos_flag got=%b exp=1", dz); end
    run_one(-16'sd5, 16'd0, q, dz, e, l);
    n_vec++; if (q !== 32'h8000_0001) begin n_err++; $display("FAIL dz_neg_q got=%h exp=80000001", q); end
    n_vec++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_neg_flag got=%b exp=1", dz); end
    run_one(16'd0, 16'd0, q, dz, e, l);
    n_vec++; if (q !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL dz_zero_q got=%h exp=7fffffff", q); end
    run_one(16'd0, 16'd7, q, dz, e, l);
    n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL zero_q got=%h exp=00000000", q); end
    n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL zero_dz got=%b exp=0", dz); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    x_i = 16'd100; y_i = 16'd10; valid_i = 1'b1;
    @(negedge clk);
    x_i = -16'sd64; y_i = 16'd8;
    @(negedge clk);
    x_i = 16'd7; y_i = -16'sd7;
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid c%0d got=%b exp=1", c, valid_o); end
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready c%0d got=%b exp=0", c, ready_o); end
      n_vec++; if (q_o !== E_100_10) begin n_err++; $display("FAIL stall_hold c%0d got=%h exp=%h", c, q_o, E_100_10); end
      if (c == 1) ready_i = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (valid_o !== 1'b1 || q_o !== E_M64_8) begin n_err++; $display("FAIL b2b_second v=%b got=%h exp=%h", valid_o, q_o, E_M64_8); end
    @(negedge clk);
    n_vec++; if (valid_o !== 1'b1 || q_o !== E_7_M7) begin n_err++; $display("FAIL b2b_third v=%b got=%h exp=%h", valid_o, q_o, E_7_M7); end
    @(negedge clk);
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", valid_o); end
  endtask

  task automatic test_reset_flight();
    int seen;
    seen = 0;
    ready_i = 1'b1;
    x_i = 16'd100; y_i = 16'd10; valid_i = 1'b1;
    @(negedge clk);
    x_i = -16'sd64; y_i = 16'd8;
    @(negedge clk);
    valid_i = 1'b0; rst_ni = 1'b0;
    @(negedge clk);
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    n_vec++; if (q_o !== 32'h0 || dz_o !== 1'b0) begin n_err++; $display("FAIL flush_data q=%h dz=%b exp=0/0", q_o, dz_o); end
    rst_ni = 1'b1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_ghost got=%0d exp=0", seen); end
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; x_i = '0; y_i = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_trunc();
    test_sat_dz();
    test_back_to_back();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
